// File: rtl/mcpu_pkg.sv
// Shared encodings for the MCPU multi-cycle control unit: FSM states,
// instruction fields, ALU commands and datapath mux select codes.
package mcpu_pkg;

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_EXEC_R   = 4'd2;
   localparam logic [3:0] S_EXEC_I   = 4'd3;
   localparam logic [3:0] S_MEM_ADDR = 4'd4;
   localparam logic [3:0] S_MEM_RD   = 4'd5;
   localparam logic [3:0] S_MEM_WR   = 4'd6;
   localparam logic [3:0] S_WB_ALU   = 4'd7;
   localparam logic [3:0] S_WB_MEM   = 4'd8;
   localparam logic [3:0] S_BRANCH   = 4'd9;
   localparam logic [3:0] S_JUMP     = 4'd10;
   localparam logic [3:0] S_JAL_LINK = 4'd11;
   localparam logic [3:0] S_JR       = 4'd12;
   localparam logic [3:0] S_TRAP     = 4'd13;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam int ALU_ADD = 0;
   localparam int ALU_SUB = 1;
   localparam int ALU_XOR = 2;
   localparam int ALU_SLT = 3;

   localparam logic [1:0] RD_RD  = 2'd0;
   localparam logic [1:0] RD_RT  = 2'd1;
   localparam logic [1:0] RD_R31 = 2'd2;

   localparam logic [1:0] MT_ALUOUT = 2'd0;
   localparam logic [1:0] MT_MDR    = 2'd1;
   localparam logic [1:0] MT_PC     = 2'd2;

   localparam logic [1:0] SB_B       = 2'd0;
   localparam logic [1:0] SB_FOUR    = 2'd1;
   localparam logic [1:0] SB_IMM     = 2'd2;
   localparam logic [1:0] SB_IMM_SH2 = 2'd3;

   localparam logic [1:0] PC_ALU    = 2'd0;
   localparam logic [1:0] PC_ALUOUT = 2'd1;
   localparam logic [1:0] PC_JUMP   = 2'd2;
   localparam logic [1:0] PC_A      = 2'd3;

   localparam logic [1:0] TC_NONE    = 2'd0;
   localparam logic [1:0] TC_ILLEGAL = 2'd1;
   localparam logic [1:0] TC_TIMEOUT = 2'd2;

   // States that own an outstanding memory request and obey the wait/timeout rule.
   function automatic logic is_mem_state(input logic [3:0] s);
      return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
   endfunction

endpackage

// File: rtl/mcpu_ctrl_fsm_if.sv
// Memory request/ready handshake between the MCPU control unit and memory.
interface mcpu_ctrl_fsm_if;
   logic mem_req;
   logic mem_we;
   logic iord;
   logic mem_ready;

   modport master (output mem_req, output mem_we, output iord, input mem_ready);
   modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/mcpu_mem_wait.sv
// Wait-state counter for one memory access; flags the ready-low cycle that
// would bring the count to MEM_TIMEOUT so the FSM can trap on that edge.
module mcpu_mem_wait #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic count,
   output logic timeout
);

   logic [7:0] wait_cnt;

   // Count consecutive ready-low cycles; restart when the access completes or none is pending.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         wait_cnt <= '0;
      else if (clear)
         wait_cnt <= '0;
      else if (count)
         wait_cnt <= wait_cnt + 8'd1;
   end

   assign timeout = count && (wait_cnt == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/mcpu_ctrl_fsm.sv
// MCPU multi-cycle control unit: sequences fetch/decode/execute/memory/writeback,
// drives all datapath enables and selects, traps on illegal opcodes and bus
// timeouts, and keeps cycle and retired-instruction counters.
module mcpu_ctrl_fsm
   import mcpu_pkg::*;
#(
   parameter int ALUOP_W     = 3,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 32,
   parameter int ENABLE_JAL  = 1
) (
   input  logic               clk,
   input  logic               reset,
   mcpu_ctrl_fsm_if.master    bus,
   input  logic [5:0]         opcode,
   input  logic [5:0]         funct,
   input  logic               zero,
   output logic               pc_we,
   output logic               ir_we,
   output logic               a_we,
   output logic               b_we,
   output logic               mdr_we,
   output logic               aluout_we,
   output logic               reg_we,
   output logic [1:0]         regdst,
   output logic [1:0]         memtoreg,
   output logic               alusrca,
   output logic [1:0]         alusrcb,
   output logic [ALUOP_W-1:0] aluop,
   output logic [1:0]         pcsrc,
   output logic [3:0]         state,
   output logic               halted,
   output logic [1:0]         trap_cause,
   output logic [CNT_W-1:0]   cycle_cnt,
   output logic [CNT_W-1:0]   instr_cnt
);

   localparam logic [ALUOP_W-1:0] CMD_ADD = ALUOP_W'(ALU_ADD);
   localparam logic [ALUOP_W-1:0] CMD_SUB = ALUOP_W'(ALU_SUB);
   localparam logic [ALUOP_W-1:0] CMD_XOR = ALUOP_W'(ALU_XOR);
   localparam logic [ALUOP_W-1:0] CMD_SLT = ALUOP_W'(ALU_SLT);
   localparam bit JAL_ON = (ENABLE_JAL != 0);

   logic [3:0]       state_q, state_d;
   logic [1:0]       cause_q, cause_d;
   logic [CNT_W-1:0] cycle_q, instr_q;
   logic             stall, wait_to, illegal;
   logic             req, req_we, req_data;

   // A pending access with no ready this cycle is a wait state.
   assign stall = is_mem_state(state_q) && !bus.mem_ready;

   mcpu_mem_wait #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait (
      .clk     (clk),
      .reset   (reset),
      .clear   (!stall),
      .count   (stall),
      .timeout (wait_to)
   );

   // Next-state and trap-cause selection; undecodable instructions funnel into one illegal flag.
   always_comb begin
      state_d = state_q;
      cause_d = TC_NONE;
      illegal = 1'b0;
      case (state_q)
         S_FETCH: begin
            if (bus.mem_ready)  state_d = S_DECODE;
            else if (wait_to) begin state_d = S_TRAP; cause_d = TC_TIMEOUT; end
         end
         S_DECODE: begin
            case (opcode)
               OP_RTYPE: begin
                  case (funct)
                     FN_ADD, FN_SUB, FN_SLT: state_d = S_EXEC_R;
                     FN_JR:   if (JAL_ON) state_d = S_JR; else illegal = 1'b1;
                     default: illegal = 1'b1;
                  endcase
               end
               OP_LW, OP_SW:     state_d = S_MEM_ADDR;
               OP_ADDI, OP_XORI: state_d = S_EXEC_I;
               OP_BEQ, OP_BNE:   state_d = S_BRANCH;
               OP_J:             state_d = S_JUMP;
               OP_JAL:  if (JAL_ON) state_d = S_JAL_LINK; else illegal = 1'b1;
               default: illegal = 1'b1;
            endcase
            if (illegal) begin state_d = S_TRAP; cause_d = TC_ILLEGAL; end
         end
         S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
         S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD: begin
            if (bus.mem_ready)  state_d = S_WB_MEM;
            else if (wait_to) begin state_d = S_TRAP; cause_d = TC_TIMEOUT; end
         end
         S_MEM_WR: begin
            if (bus.mem_ready)  state_d = S_FETCH;
            else if (wait_to) begin state_d = S_TRAP; cause_d = TC_TIMEOUT; end
         end
         S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP, S_JAL_LINK, S_JR: state_d = S_FETCH;
         S_TRAP:  state_d = S_TRAP;
         default: state_d = S_FETCH;
      endcase
   end

   // State, trap cause (latched on entry, so the first cause wins) and perf counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_FETCH;
         cause_q <= TC_NONE;
         cycle_q <= '0;
         instr_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q != S_TRAP && state_d == S_TRAP) cause_q <= cause_d;
         if (state_q != S_TRAP) cycle_q <= cycle_q + CNT_W'(1);
         if (state_q != S_FETCH && state_d == S_FETCH) instr_q <= instr_q + CNT_W'(1);
      end
   end

   // Datapath controls per state; everything is forced low while reset is held.
   always_comb begin
      req = 1'b0;  req_we = 1'b0;  req_data = 1'b0;
      pc_we = 1'b0;  ir_we = 1'b0;  a_we = 1'b0;  b_we = 1'b0;
      mdr_we = 1'b0;  aluout_we = 1'b0;  reg_we = 1'b0;
      regdst = RD_RD;  memtoreg = MT_ALUOUT;  alusrca = 1'b0;
      alusrcb = SB_B;  aluop = CMD_ADD;  pcsrc = PC_ALU;
      if (reset) begin
         case (state_q)
            S_FETCH: begin
               req = 1'b1;  alusrcb = SB_FOUR;
               ir_we = bus.mem_ready;  pc_we = bus.mem_ready;
            end
            S_DECODE: begin
               a_we = 1'b1;  b_we = 1'b1;  aluout_we = 1'b1;  alusrcb = SB_IMM_SH2;
            end
            S_EXEC_R: begin
               alusrca = 1'b1;  aluout_we = 1'b1;
               case (funct)
                  FN_SUB:  aluop = CMD_SUB;
                  FN_SLT:  aluop = CMD_SLT;
                  default: aluop = CMD_ADD;
               endcase
            end
            S_EXEC_I: begin
               alusrca = 1'b1;  alusrcb = SB_IMM;  aluout_we = 1'b1;
               aluop = (opcode == OP_XORI) ? CMD_XOR : CMD_ADD;
            end
            S_MEM_ADDR: begin
               alusrca = 1'b1;  alusrcb = SB_IMM;  aluout_we = 1'b1;
            end
            S_MEM_RD: begin
               req = 1'b1;  req_data = 1'b1;  mdr_we = bus.mem_ready;
            end
            S_MEM_WR: begin
               req = 1'b1;  req_we = 1'b1;  req_data = 1'b1;
            end
            S_WB_ALU: begin
               reg_we = 1'b1;  regdst = (opcode == OP_RTYPE) ? RD_RD : RD_RT;
            end
            S_WB_MEM: begin
               reg_we = 1'b1;  regdst = RD_RT;  memtoreg = MT_MDR;
            end
            S_BRANCH: begin
               alusrca = 1'b1;  aluop = CMD_SUB;  pcsrc = PC_ALUOUT;
               pc_we = (opcode == OP_BEQ) ? zero : !zero;
            end
            S_JUMP: begin
               pcsrc = PC_JUMP;  pc_we = 1'b1;
            end
            S_JAL_LINK: begin
               reg_we = 1'b1;  regdst = RD_R31;  memtoreg = MT_PC;
               pcsrc = PC_JUMP;  pc_we = 1'b1;
            end
            S_JR: begin
               pcsrc = PC_A;  pc_we = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.mem_req  = req;
   assign bus.mem_we   = req_we;
   assign bus.iord     = req_data;
   assign state        = state_q;
   assign halted       = (state_q == S_TRAP);
   assign trap_cause   = cause_q;
   assign cycle_cnt    = cycle_q;
   assign instr_cnt    = instr_q;

endmodule

// File: tb/tb_mcpu_ctrl_fsm.sv
// Directed bench for mcpu_ctrl_fsm: a per-cycle vector table walks one of
// every instruction class, then hand-written sequences cover reset during a
// stalled store, illegal opcodes, JAL with JAL disabled and the bus timeout.
module tb_mcpu_ctrl_fsm;
   import mcpu_pkg::*;

   typedef struct {
      logic [5:0]  op;
      logic [5:0]  fn;
      logic        z;
      logic        r;
      logic [3:0]  st;
      logic [9:0]  ctl;
      logic [11:0] sel;
      int          ic;
   } vec_t;

   // ctl = {mem_req, mem_we, iord, pc_we, ir_we, a_we, b_we, mdr_we, aluout_we, reg_we}
   localparam logic [9:0] C_NONE   = 10'b0000000000;
   localparam logic [9:0] C_FETCH  = 10'b1001100000;
   localparam logic [9:0] C_DEC    = 10'b0000011010;
   localparam logic [9:0] C_ALUOUT = 10'b0000000010;
   localparam logic [9:0] C_REG    = 10'b0000000001;
   localparam logic [9:0] C_PC     = 10'b0001000000;
   localparam logic [9:0] C_PCREG  = 10'b0001000001;
   localparam logic [9:0] C_WR     = 10'b1110000000;
   localparam logic [9:0] C_RD     = 10'b1010000000;
   localparam logic [9:0] C_RDDONE = 10'b1010000100;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] opcode = 6'h00;
   logic [5:0] funct = 6'h00;
   logic       zero = 1'b0;
   logic       rdy = 1'b0;
   int         errors = 0;
   int         checks = 0;
   vec_t       tv[$];

   mcpu_ctrl_fsm_if bus ();
   mcpu_ctrl_fsm_if bus_nj ();
   assign bus.mem_ready    = rdy;
   assign bus_nj.mem_ready = rdy;

   logic        pc_we, ir_we, a_we, b_we, mdr_we, aluout_we, reg_we, alusrca, halted;
   logic [1:0]  regdst, memtoreg, alusrcb, pcsrc, trap_cause;
   logic [2:0]  aluop;
   logic [3:0]  state;
   logic [31:0] cycle_cnt, instr_cnt;

   logic        nj_pc_we, nj_ir_we, nj_a_we, nj_b_we, nj_mdr_we, nj_aluout_we, nj_reg_we;
   logic        nj_alusrca, nj_halted;
   logic [1:0]  nj_regdst, nj_memtoreg, nj_alusrcb, nj_pcsrc, nj_trap_cause;
   logic [2:0]  nj_aluop;
   logic [3:0]  nj_state;
   logic [31:0] nj_cycle_cnt, nj_instr_cnt;

   mcpu_ctrl_fsm dut (
      .clk(clk), .reset(reset), .bus(bus),
      .opcode(opcode), .funct(funct), .zero(zero),
      .pc_we(pc_we), .ir_we(ir_we), .a_we(a_we), .b_we(b_we), .mdr_we(mdr_we),
      .aluout_we(aluout_we), .reg_we(reg_we), .regdst(regdst), .memtoreg(memtoreg),
      .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc),
      .state(state), .halted(halted), .trap_cause(trap_cause),
      .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
   );

   mcpu_ctrl_fsm #(.ENABLE_JAL(0)) dut_nj (
      .clk(clk), .reset(reset), .bus(bus_nj),
      .opcode(opcode), .funct(funct), .zero(zero),
      .pc_we(nj_pc_we), .ir_we(nj_ir_we), .a_we(nj_a_we), .b_we(nj_b_we),
      .mdr_we(nj_mdr_we), .aluout_we(nj_aluout_we), .reg_we(nj_reg_we),
      .regdst(nj_regdst), .memtoreg(nj_memtoreg), .alusrca(nj_alusrca),
      .alusrcb(nj_alusrcb), .aluop(nj_aluop), .pcsrc(nj_pcsrc),
      .state(nj_state), .halted(nj_halted), .trap_cause(nj_trap_cause),
      .cycle_cnt(nj_cycle_cnt), .instr_cnt(nj_instr_cnt)
   );

   wire [9:0]  ctl = {bus.mem_req, bus.mem_we, bus.iord, pc_we, ir_we, a_we, b_we,
                      mdr_we, aluout_we, reg_we};
   wire [11:0] sel = {regdst, memtoreg, alusrca, alusrcb, aluop, pcsrc};

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [11:0] sl(input logic [1:0] rd, input logic [1:0] mt,
                                      input logic sa, input logic [1:0] sb,
                                      input logic [2:0] ao, input logic [1:0] ps);
      return {rd, mt, sa, sb, ao, ps};
   endfunction

   task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic r,
                      input logic [3:0] st, input logic [9:0] c, input logic [11:0] s, input int ic);
      vec_t v;
      v.op = op; v.fn = fn; v.z = z; v.r = r; v.st = st; v.ctl = c; v.sel = s; v.ic = ic;
      tv.push_back(v);
   endtask

   // FETCH (ready at once) followed by DECODE for one instruction.
   task automatic add_fd(input logic [5:0] op, input logic [5:0] fn, input logic z, input int ic);
      add(op, fn, z, 1'b1, S_FETCH,  C_FETCH, sl(0, 0, 0, 1, 0, 0), ic);
      add(op, fn, z, 1'b1, S_DECODE, C_DEC,   sl(0, 0, 0, 3, 0, 0), ic);
   endtask

   // Assert reset for one clock, release on a falling edge.
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      #2;
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      logic found;
      logic ok;

      add_fd(6'h00, 6'h20, 1'b0, 0);
      add(6'h00, 6'h20, 0, 1, S_EXEC_R,   C_ALUOUT, sl(0, 0, 1, 0, 0, 0), 0);
      add(6'h00, 6'h20, 0, 1, S_WB_ALU,   C_REG,    sl(0, 0, 0, 0, 0, 0), 0);
      add_fd(6'h00, 6'h22, 1'b0, 1);
      add(6'h00, 6'h22, 0, 1, S_EXEC_R,   C_ALUOUT, sl(0, 0, 1, 0, 1, 0), 1);
      add(6'h00, 6'h22, 0, 1, S_WB_ALU,   C_REG,    sl(0, 0, 0, 0, 0, 0), 1);
      add_fd(6'h00, 6'h2A, 1'b0, 2);
      add(6'h00, 6'h2A, 0, 1, S_EXEC_R,   C_ALUOUT, sl(0, 0, 1, 0, 3, 0), 2);
      add(6'h00, 6'h2A, 0, 1, S_WB_ALU,   C_REG,    sl(0, 0, 0, 0, 0, 0), 2);
      add_fd(6'h0E, 6'h00, 1'b0, 3);
      add(6'h0E, 6'h00, 0, 1, S_EXEC_I,   C_ALUOUT, sl(0, 0, 1, 2, 2, 0), 3);
      add(6'h0E, 6'h00, 0, 1, S_WB_ALU,   C_REG,    sl(1, 0, 0, 0, 0, 0), 3);
      add_fd(6'h08, 6'h00, 1'b0, 4);
      add(6'h08, 6'h00, 0, 1, S_EXEC_I,   C_ALUOUT, sl(0, 0, 1, 2, 0, 0), 4);
      add(6'h08, 6'h00, 0, 1, S_WB_ALU,   C_REG,    sl(1, 0, 0, 0, 0, 0), 4);
      add_fd(6'h04, 6'h00, 1'b1, 5);
      add(6'h04, 6'h00, 1, 1, S_BRANCH,   C_PC,     sl(0, 0, 1, 0, 1, 1), 5);
      add_fd(6'h05, 6'h00, 1'b1, 6);
      add(6'h05, 6'h00, 1, 1, S_BRANCH,   C_NONE,   sl(0, 0, 1, 0, 1, 1), 6);
      add_fd(6'h02, 6'h00, 1'b0, 7);
      add(6'h02, 6'h00, 0, 1, S_JUMP,     C_PC,     sl(0, 0, 0, 0, 0, 2), 7);
      add_fd(6'h03, 6'h00, 1'b0, 8);
      add(6'h03, 6'h00, 0, 1, S_JAL_LINK, C_PCREG,  sl(2, 2, 0, 0, 0, 2), 8);
      add_fd(6'h00, 6'h08, 1'b0, 9);
      add(6'h00, 6'h08, 0, 1, S_JR,       C_PC,     sl(0, 0, 0, 0, 0, 3), 9);
      add_fd(6'h2B, 6'h00, 1'b0, 10);
      add(6'h2B, 6'h00, 0, 1, S_MEM_ADDR, C_ALUOUT, sl(0, 0, 1, 2, 0, 0), 10);
      add(6'h2B, 6'h00, 0, 1, S_MEM_WR,   C_WR,     sl(0, 0, 0, 0, 0, 0), 10);
      add_fd(6'h23, 6'h00, 1'b0, 11);
      add(6'h23, 6'h00, 0, 1, S_MEM_ADDR, C_ALUOUT, sl(0, 0, 1, 2, 0, 0), 11);
      add(6'h23, 6'h00, 0, 0, S_MEM_RD,   C_RD,     sl(0, 0, 0, 0, 0, 0), 11);
      add(6'h23, 6'h00, 0, 0, S_MEM_RD,   C_RD,     sl(0, 0, 0, 0, 0, 0), 11);
      add(6'h23, 6'h00, 0, 0, S_MEM_RD,   C_RD,     sl(0, 0, 0, 0, 0, 0), 11);
      add(6'h23, 6'h00, 0, 1, S_MEM_RD,   C_RDDONE, sl(0, 0, 0, 0, 0, 0), 11);
      add(6'h23, 6'h00, 0, 1, S_WB_MEM,   C_REG,    sl(1, 1, 0, 0, 0, 0), 11);
      add_fd(6'h00, 6'h20, 1'b0, 12);

      // Reset state: outputs quiet even with memory signalling ready.
      #3 reset = 1'b0;
      rdy = 1'b1;
      #1;
      check("rst_state", state, S_FETCH);
      check("rst_ctl", ctl, C_NONE);
      check("rst_sel", sel, 12'h000);
      check("rst_cycle_cnt", cycle_cnt, 0);
      check("rst_instr_cnt", instr_cnt, 0);
      check("rst_halted", halted, 0);
      check("rst_trap_cause", trap_cause, 0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < tv.size(); i++) begin
         opcode = tv[i].op;
         funct  = tv[i].fn;
         zero   = tv[i].z;
         rdy    = tv[i].r;
         #1;
         check($sformatf("v%0d_state", i), state, tv[i].st);
         check($sformatf("v%0d_ctl", i), ctl, tv[i].ctl);
         check($sformatf("v%0d_sel", i), sel, tv[i].sel);
         check($sformatf("v%0d_instr_cnt", i), instr_cnt, tv[i].ic);
         @(negedge clk);
      end

      // Reset in the middle of a stalled store.
      opcode = 6'h2B; funct = 6'h00; rdy = 1'b1; found = 1'b0;
      for (int k = 0; k < 12 && !found; k++) begin
         #1;
         if (state == S_MEM_WR) begin
            found = 1'b1;
            rdy = 1'b0;
         end else begin
            @(negedge clk);
         end
      end
      check("reach_mem_wr", found, 1);
      @(negedge clk);
      @(negedge clk);
      #1;
      check("memwr_wait_state", state, S_MEM_WR);
      check("memwr_wait_ctl", ctl, C_WR);
      check("memwr_instr_cnt", instr_cnt, 13);
      reset = 1'b0;
      #1;
      check("midrst_state", state, S_FETCH);
      check("midrst_ctl", ctl, C_NONE);
      check("midrst_sel", sel, 12'h000);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("midrst_cycle_cnt", cycle_cnt, 0);
      check("midrst_instr_cnt", instr_cnt, 0);

      // Illegal opcode traps from DECODE.
      @(negedge clk);
      opcode = 6'h3F; rdy = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("ill_state", state, S_TRAP);
      check("ill_cause", trap_cause, 1);
      check("ill_halted", halted, 1);
      check("ill_ctl", ctl, C_NONE);

      // JAL: link and jump in one cycle, or illegal when JAL is disabled.
      do_reset();
      opcode = 6'h03; funct = 6'h00; rdy = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("jal_state", state, S_JAL_LINK);
      check("jal_ctl", ctl, C_PCREG);
      check("jal_sel", sel, sl(2, 2, 0, 0, 0, 2));
      check("nojal_state", nj_state, S_TRAP);
      check("nojal_cause", nj_trap_cause, 1);
      check("nojal_halted", nj_halted, 1);

      // Fetch never answered: trap after exactly 15 wait cycles, counter frozen.
      do_reset();
      opcode = 6'h00; rdy = 1'b0; ok = 1'b1;
      for (int k = 0; k < 15; k++) begin
         #1;
         if (state != S_FETCH || bus.mem_req !== 1'b1) ok = 1'b0;
         @(negedge clk);
      end
      check("to_wait_fetch", ok, 1);
      #1;
      check("to_state", state, S_TRAP);
      check("to_halted", halted, 1);
      check("to_cause", trap_cause, 2);
      check("to_cycle_cnt", cycle_cnt, 15);
      check("to_ctl", ctl, C_NONE);
      rdy = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      check("to_hold_state", state, S_TRAP);
      check("to_hold_cycle_cnt", cycle_cnt, 15);
      check("to_hold_cause", trap_cause, 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
